// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and encodings for the two-port memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Controller phase: initialisation sweep, then normal arbitration
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    // Requester encoding shared by the round-robin pointer and read owner
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter with one-hot grant and a
//                registered pointer holding the last granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       last
);

    logic r_last;

    // Lone requester always wins; on contention the one not granted last wins
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (r_last == REQ_A) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer records the last winner; reset value makes A the first favourite
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= REQ_B;
        end else if (advance && (gnt != 2'b00)) begin
            r_last <= gnt[1] ? REQ_B : REQ_A;
        end
    end

    assign last = r_last;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port synchronous memory between two
//                requesters. Initialises every location to INIT_VALUE after
//                reset, then serves one round-robin arbitrated access per
//                cycle and routes read data back to its owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0] mem_r_data
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = {ADDR_WIDTH{1'b1}};

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  w_run;
    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_last_gnt;
    logic                  r_rd_pending;
    logic                  r_rd_owner;
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;

    assign w_run = (r_state == ST_RUN);
    // Requests stay invisible to the arbiter until the sweep is finished
    assign w_req = {b_req, a_req} & {2{w_run}};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_run),
        .gnt     (w_gnt),
        .last    (w_last_gnt)
    );

    assign a_gnt = w_gnt[0];
    assign b_gnt = w_gnt[1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leave the sweep after the top address has been written
    always_comb begin
        w_state_next = r_state;
        if ((r_state == ST_INIT) && (r_cnt == c_last_addr)) begin
            w_state_next = ST_RUN;
        end
    end

    // Sweep address counter, one location per cycle while initialising
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Memory command mux: sweep writes, else the granted requester's op
    always_comb begin
        init_done    = (r_state == ST_RUN);
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        mem_addr     = '0;
        mem_w_data   = '0;
        if (r_state == ST_INIT) begin
            mem_write_en = 1'b1;
            mem_addr     = r_cnt;
            mem_w_data   = INIT_VALUE;
        end else if (w_gnt[0]) begin
            mem_write_en = a_we;
            mem_read_en  = ~a_we;
            mem_addr     = a_addr;
            mem_w_data   = a_wdata;
        end else if (w_gnt[1]) begin
            mem_write_en = b_we;
            mem_read_en  = ~b_we;
            mem_addr     = b_addr;
            mem_w_data   = b_wdata;
        end
    end

    // Remember who issued the read so the returning data can be steered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pending <= 1'b0;
            r_rd_owner   <= REQ_A;
        end else begin
            r_rd_pending <= mem_read_en;
            if (mem_read_en) begin
                r_rd_owner <= w_gnt[1] ? REQ_B : REQ_A;
            end
        end
    end

    // The pointer always names the requester granted in the previous cycle
    always_comb begin
        if (r_rd_pending) begin
            assert (r_rd_owner == w_last_gnt);
        end
    end

    assign a_rvalid = r_rd_pending && (r_rd_owner == REQ_A);
    assign b_rvalid = r_rd_pending && (r_rd_owner == REQ_B);

    // Hold the last returned word so rdata is stable between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (a_rvalid) r_a_rdata <= mem_r_data;
            if (b_rvalid) r_b_rdata <= mem_r_data;
        end
    end

    assign a_rdata = a_rvalid ? mem_r_data : r_a_rdata;
    assign b_rdata = b_rvalid ? mem_r_data : r_b_rdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with a behavioural
//                single-port memory and a read-data scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [5:0]  a_addr = '0;
    logic [63:0] a_wdata = '0;
    logic        a_gnt, a_rvalid;
    logic [63:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [5:0]  b_addr = '0;
    logic [63:0] b_wdata = '0;
    logic        b_gnt, b_rvalid;
    logic [63:0] b_rdata;
    logic        mem_write_en, mem_read_en;
    logic [5:0]  mem_addr;
    logic [63:0] mem_w_data;
    logic [63:0] mem_r_data = '0;

    logic [63:0] mem [64];
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_port_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .INIT_VALUE('hFF)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with registered read data
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_w_data;
        if (mem_read_en)  mem_r_data    <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: enable exclusivity every cycle, read data against scoreboard
    initial forever begin
        @(negedge clk);
        #2;
        check("mem_en_exclusive", {127'd0, mem_write_en & mem_read_en}, 128'd0);
        if (a_rvalid) begin
            if (exp_a.size() == 0) check("a_rvalid_unexpected", 128'd1, 128'd0);
            else check("a_rdata", {64'd0, a_rdata}, {64'd0, exp_a.pop_front()});
        end
        if (b_rvalid) begin
            if (exp_b.size() == 0) check("b_rvalid_unexpected", 128'd1, 128'd0);
            else check("b_rdata", {64'd0, b_rdata}, {64'd0, exp_b.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Assert reset for one cycle, check cleared outputs, release at a negedge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_outputs", {121'd0, init_done, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_read_en, 1'b0},
              128'd0);
        check("reset_rdata", {a_rdata, b_rdata}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // 64 sweep writes of 'hFF to addresses 0..63, then init_done
    task automatic check_sweep();
        for (int i = 0; i < 64; i++) begin
            #1;
            check($sformatf("sweep_%0d", i),
                  {53'd0, mem_write_en, mem_read_en, init_done, a_gnt, b_gnt, mem_addr, mem_w_data},
                  {53'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'(i), 64'hFF});
            @(negedge clk);
        end
        #1;
        check("init_done_at_64", {127'd0, init_done}, 128'd1);
    endtask

    // One lone-requester access; reads push their expected data
    task automatic single_op(input bit port_b, input bit we, input logic [5:0] addr,
                             input logic [63:0] data, input logic [63:0] exp_rd);
        if (!port_b) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data; end
        else         begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data; end
        #1;
        check("single_gnt", {126'd0, a_gnt, b_gnt}, {126'd0, ~port_b, port_b});
        if (!we) begin
            if (!port_b) exp_a.push_back(exp_rd);
            else         exp_b.push_back(exp_rd);
        end
        @(negedge clk);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        // Test 1: sweep with no requests, then read back an initialised word
        do_reset();
        check_sweep();
        @(negedge clk);
        single_op(1'b0, 1'b0, 6'd33, 64'd0, 64'hFF);
        repeat (2) @(negedge clk);

        // Test 2: A write held through the sweep, then read-after-write
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd5; a_wdata = 64'hDEAD_BEEF_0000_0001;
        do_reset();
        check_sweep();
        check("t2_first_run_gnt", {120'd0, a_gnt, b_gnt, mem_write_en, mem_addr},
              {120'd0, 1'b1, 1'b0, 1'b1, 6'd5});
        @(negedge clk);
        single_op(1'b0, 1'b0, 6'd5, 64'd0, 64'hDEAD_BEEF_0000_0001);
        repeat (2) @(negedge clk);

        // Test 4: last winner was A, so B's read of 10 goes before A's write
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd10; a_wdata = 64'h1234;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd10;
        #1;
        check("t4_b_wins", {126'd0, a_gnt, b_gnt}, {126'd0, 2'b01});
        exp_b.push_back(64'hFF);
        @(negedge clk);
        b_req = 1'b0;
        #1;
        check("t4_a_next", {126'd0, a_gnt, b_gnt}, {126'd0, 2'b10});
        @(negedge clk);
        a_req = 1'b0;
        single_op(1'b1, 1'b0, 6'd10, 64'd0, 64'h1234);
        repeat (2) @(negedge clk);

        // Test 6: reset right after an A read grant suppresses the rvalid
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd7;
        #1;
        check("t6_gnt", {126'd0, a_gnt, b_gnt}, {126'd0, 2'b10});
        @(posedge clk);
        #1;
        rst = 1'b1;
        a_req = 1'b0;
        @(negedge clk);
        #1;
        check("t6_no_rvalid", {126'd0, a_rvalid, b_rvalid}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        check_sweep();
        @(negedge clk);

        // Test 3: both request every cycle; A first after reset, then alternate
        for (int i = 0; i < 6; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = 6'(20 + i); a_wdata = 64'(8'hA0 + i);
            b_req = 1'b1; b_we = 1'b0; b_addr = 6'(40 + i);
            #1;
            check($sformatf("t3_alt_%0d", i), {126'd0, a_gnt, b_gnt},
                  {126'd0, (i % 2 == 0), (i % 2 == 1)});
            if (i % 2 == 1) exp_b.push_back(64'hFF);
            @(negedge clk);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        single_op(1'b0, 1'b0, 6'd20, 64'd0, 64'hA0);
        single_op(1'b0, 1'b0, 6'd22, 64'd0, 64'hA2);
        single_op(1'b1, 1'b0, 6'd21, 64'd0, 64'hFF);
        repeat (2) @(negedge clk);

        // Test 5: reset at sweep address 20 restarts the full sweep from 0
        do_reset();
        repeat (20) @(negedge clk);
        #1;
        check("t5_cnt20", {122'd0, mem_addr}, {122'd0, 6'd20});
        rst = 1'b1;
        #1;
        check("t5_clear", {115'd0, init_done, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_read_en, 1'b0, mem_addr},
              128'd0);
        @(negedge clk);
        rst = 1'b0;
        check_sweep();
        @(negedge clk);
        single_op(1'b0, 1'b0, 6'd22, 64'd0, 64'hFF);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 128'(exp_a.size() + exp_b.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
